// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Single-port word memory that services one CPU request at a
//                time with a fixed, programmable number of wait states.
//                IDLE captures a request, BUSY counts down the wait states
//                and performs the access, RESP presents a one-cycle
//                completion pulse.
//  Ports       : iClk      - clock, all logic on its rising edge
//                iRst      - synchronous active-high reset
//                iMemEn    - request present
//                iMemRW    - 1 = write, 0 = read
//                iMemAddr  - byte address (bits [1:0] ignored)
//                iMemData  - write data
//                oMemData  - read data (0 for writes and errors)
//                oMemReady - one-cycle completion pulse
//                oMemErr   - completing access was out of range
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iMemEn,
    input  logic        iMemRW,
    input  logic [31:0] iMemAddr,
    input  logic [31:0] iMemData,
    output logic [31:0] oMemData,
    output logic        oMemReady,
    output logic        oMemErr
);

    localparam int         c_DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    logic [1:0]            r_state;
    logic [3:0]            r_wait;
    logic [31:2]           r_addr;   // byte-offset bits are never used
    logic [31:0]           r_wdata;
    logic                  r_rw;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic                  r_ready;

    logic [31:0]           r_mem [0:c_DEPTH-1];

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_oor;
    logic                  w_access;
    logic                  w_do_write;

    assign w_idx = r_addr[DEPTH_LOG2+1:2];

    // Any address bit above the memory window flags the access as out of
    // range; a memory that spans the whole address space never errors.
    generate
        if (DEPTH_LOG2 + 2 < 32) begin : g_range_chk
            assign w_oor = |r_addr[31:DEPTH_LOG2+2];
        end else begin : g_full_range
            assign w_oor = 1'b0;
        end
    endgenerate

    // The access happens on the BUSY edge where the wait counter has expired.
    assign w_access   = (r_state == c_S_BUSY) && (r_wait == 4'd0);
    assign w_do_write = w_access && r_rw && !w_oor;

    // Memory contents deliberately survive reset; reset only blocks the
    // write so an abandoned access never lands.
    always_ff @(posedge iClk) begin
        if (!iRst && w_do_write) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= c_S_IDLE;
            r_wait  <= 4'd0;
            r_addr  <= 30'd0;
            r_wdata <= 32'd0;
            r_rw    <= 1'b0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_ready <= 1'b0;
                    if (iMemEn) begin
                        r_addr  <= iMemAddr[31:2];
                        r_wdata <= iMemData;
                        r_rw    <= iMemRW;
                        r_wait  <= c_WAIT_INIT;
                        r_state <= c_S_BUSY;
                    end
                end
                c_S_BUSY: begin
                    if (r_wait != 4'd0) begin
                        r_wait <= r_wait - 4'd1;
                    end else begin
                        r_state <= c_S_RESP;
                        r_ready <= 1'b1;
                        if (w_oor) begin
                            r_rdata <= 32'd0;
                            r_err   <= 1'b1;
                        end else if (r_rw) begin
                            r_rdata <= 32'd0;
                            r_err   <= 1'b0;
                        end else begin
                            r_rdata <= r_mem[w_idx];
                            r_err   <= 1'b0;
                        end
                    end
                end
                c_S_RESP: begin
                    // Data and error are held; only the pulse drops.
                    r_ready <= 1'b0;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign oMemData  = r_rdata;
    assign oMemReady = r_ready;
    assign oMemErr   = r_err;

endmodule
`default_nettype wire
